// File: rtl/writeback_unit.sv
// writeback_unit: in-order FIFO that drains up to two execution results per cycle onto the register writeback ports
//   clock_i, reset_i          : clock, synchronous active-high reset
//   srcValid_i/Address_i/Data_i : per-source result, source 0 oldest
//   stall_o                   : execution units must hold new results
//   overflow_o                : sticky, a result was dropped
//   reg{1,2}isWriteback_o/WritebackAddress_o/WritebackData_o : writeback ports, port 1 older
//   occupancy_o               : FIFO entry count
module writeback_unit #(
  parameter int addressSize = 64,
  parameter int regWidth = 5,
  parameter int numSources = 3,
  parameter int depth = 8,
  parameter int ptrWidth = 3
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [numSources-1:0]            srcValid_i,
  input  logic [numSources*regWidth-1:0]   srcAddress_i,
  input  logic [numSources*addressSize-1:0] srcData_i,
  output logic                             stall_o,
  output logic                             overflow_o,
  output logic                             reg1isWriteback_o,
  output logic [regWidth-1:0]              reg1WritebackAddress_o,
  output logic [addressSize-1:0]           reg1WritebackData_o,
  output logic                             reg2isWriteback_o,
  output logic [regWidth-1:0]              reg2WritebackAddress_o,
  output logic [addressSize-1:0]           reg2WritebackData_o,
  output logic [ptrWidth:0]                occupancy_o
);
  localparam int EW = regWidth + addressSize;
  localparam logic [ptrWidth:0] ONE = (ptrWidth+1)'(1);
  localparam logic [ptrWidth:0] TWO = (ptrWidth+1)'(2);
  logic [EW-1:0] mem [depth];
  logic [ptrWidth-1:0] head, tail;
  logic [ptrWidth:0] count, deq, space, enq;
  logic [ptrWidth:0] off [numSources];
  logic [numSources-1:0] keep;
  logic drop;
  assign occupancy_o = count;
  assign stall_o = count > (ptrWidth+1)'(depth - numSources);
  // free slots are counted after this edge's dequeue; sources claim them in index order
  always_comb begin
    deq = (count > ONE) ? TWO : count;
    space = (ptrWidth+1)'(depth) - count + deq;
    enq = '0;
    drop = 1'b0;
    keep = '0;
    for (int k = 0; k < numSources; k++) begin
      off[k] = enq;
      keep[k] = srcValid_i[k] && (enq < space);
      drop = drop | (srcValid_i[k] & ~keep[k]);
      enq = enq + {{ptrWidth{1'b0}}, keep[k]};
    end
  end
  always_ff @(posedge clock_i)
    if (!reset_i)
      for (int k = 0; k < numSources; k++)
        if (keep[k])
          mem[tail + off[k][ptrWidth-1:0]] <= {srcAddress_i[k*regWidth +: regWidth], srcData_i[k*addressSize +: addressSize]};
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow_o <= 1'b0;
      reg1isWriteback_o <= 1'b0;
      reg2isWriteback_o <= 1'b0;
      {reg1WritebackAddress_o, reg1WritebackData_o} <= '0;
      {reg2WritebackAddress_o, reg2WritebackData_o} <= '0;
    end else begin
      head <= head + deq[ptrWidth-1:0];
      tail <= tail + enq[ptrWidth-1:0];
      count <= count + enq - deq;
      overflow_o <= overflow_o | drop;
      reg1isWriteback_o <= count != '0;
      reg2isWriteback_o <= count > ONE;
      if (count != '0) {reg1WritebackAddress_o, reg1WritebackData_o} <= mem[head];
      if (count > ONE) {reg2WritebackAddress_o, reg2WritebackData_o} <= mem[head + 1'b1];
    end
  end
endmodule
